// File: rtl/breakout_pkg.sv
// breakout_pkg: constants and types shared by the breakout game blocks
// (ball engine, brick block, frame tick decoder).
//   H_ACTIVE / V_ACTIVE : visible area of the 640x480 scan
//   VBLANK_LINE         : first line of vertical blanking (frame tick line)
//   COL_BALL / COL_BG   : 3-bit pixel colours
//   ball_state_t        : ball engine FSM states
package breakout_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int VBLANK_LINE = 480;

    localparam logic [2:0] COL_BALL = 3'b111;
    localparam logic [2:0] COL_BG   = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_MISS = 2'd2,
        ST_OVER = 2'd3
    } ball_state_t;

endpackage

// File: rtl/frame_tick.sv
// frame_tick: decodes the scan position into a one-cycle frame tick at the
// first pixel of vertical blanking. The scan position advances every pixel
// clock, so the decode is high for exactly one cycle per frame.
//   hor_count_i : scan column, 0..799
//   ver_count_i : scan line, 0..524
//   tick_o      : high while the scan sits at (0, VBLANK_LINE)
module frame_tick
    import breakout_pkg::*;
(
    input  logic [9:0] hor_count_i,
    input  logic [9:0] ver_count_i,
    output logic       tick_o
);

    assign tick_o = (hor_count_i == 10'd0) && (ver_count_i == 10'(VBLANK_LINE));

endmodule

// File: rtl/ball_engine.sv
// ball_engine: ball motion, wall/ceiling/paddle reflection, miss detection
// and life counting for the breakout game, plus the registered ball pixel.
// Motion and the FSM advance only on the frame tick (start of vblank).
//   CLK_25MH   : pixel clock
//   reset      : asynchronous, active-high
//   hor_count  : scan column 0..799
//   ver_count  : scan line 0..524
//   paddle_pos : paddle left edge, sampled at the tick
//   launch     : serve request, sampled at the tick while IDLE
//   ball_rgb   : 3'b111 on a visible ball pixel, one cycle after the scan
//   ball_x/y   : ball top-left corner
//   lives      : remaining lives
//   miss_pulse : one cycle high after a miss tick
//   game_over  : high once lives reach zero
module ball_engine
    import breakout_pkg::*;
#(
    parameter int BALL_SIZE   = 8,
    parameter int SPEED       = 2,
    parameter int PADDLE_W    = 100,
    parameter int PADDLE_TOP  = 441,
    parameter int LIVES       = 3,
    parameter int MISS_FRAMES = 60
) (
    input  logic       CLK_25MH,
    input  logic       reset,
    input  logic [9:0] hor_count,
    input  logic [9:0] ver_count,
    input  logic [9:0] paddle_pos,
    input  logic       launch,
    output logic [2:0] ball_rgb,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [1:0] lives,
    output logic       miss_pulse,
    output logic       game_over
);

    localparam logic [9:0]  PARK_Y   = 10'(PADDLE_TOP - BALL_SIZE);
    localparam logic [9:0]  X_MAX    = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0]  RST_X    = 10'd316;
    localparam logic [10:0] PARK_OFS = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [10:0] BS_U     = 11'(BALL_SIZE);
    localparam logic [10:0] HALF_B   = 11'(BALL_SIZE / 2);
    localparam logic [10:0] PW_U     = 11'(PADDLE_W);
    localparam logic [10:0] HALF_PW  = 11'(PADDLE_W / 2);
    localparam logic [10:0] PT_U     = 11'(PADDLE_TOP);

    localparam logic signed [11:0] BS_S   = 12'(BALL_SIZE);
    localparam logic signed [11:0] SPD_S  = 12'(SPEED);
    localparam logic signed [11:0] PT_S   = 12'(PADDLE_TOP);
    localparam logic signed [11:0] HACT_S = 12'(H_ACTIVE);
    localparam logic signed [11:0] VACT_S = 12'(V_ACTIVE);

    localparam int              MCW       = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
    localparam logic [MCW-1:0]  MISS_LAST = MCW'(MISS_FRAMES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ball_state_t     state_q;
    logic [9:0]      ball_x_q, ball_y_q;
    logic            dx_neg_q, dy_neg_q;     // 1 = moving left / up
    logic [1:0]      lives_q;
    logic [MCW-1:0]  miss_cnt_q;
    logic            miss_pulse_q;
    logic            game_over_q;
    logic [2:0]      ball_rgb_q;

    // ------------------------------------------------------------------
    // Frame tick
    // ------------------------------------------------------------------
    logic tick;

    frame_tick u_frame_tick (
        .hor_count_i (hor_count),
        .ver_count_i (ver_count),
        .tick_o      (tick)
    );

    // ------------------------------------------------------------------
    // Axis update for the RUN state
    // ------------------------------------------------------------------
    logic signed [11:0] nx, ny;
    logic [10:0]        pad_u, bx_u, by_u, park_sum;
    logic               paddle_hit, centre_left, run_miss;
    logic [9:0]         ball_x_d, ball_y_d, park_x;
    logic               dx_neg_d, dy_neg_d;

    always_comb begin
        nx    = $signed({2'b00, ball_x_q}) + (dx_neg_q ? -SPD_S : SPD_S);
        ny    = $signed({2'b00, ball_y_q}) + (dy_neg_q ? -SPD_S : SPD_S);
        pad_u = {1'b0, paddle_pos};
        bx_u  = {1'b0, ball_x_q};
        by_u  = {1'b0, ball_y_q};

        // Hit only when the ball crosses the paddle top this tick while
        // overlapping the paddle horizontally.
        paddle_hit  = !dy_neg_q
                      && (by_u + BS_U <= PT_U)
                      && (ny + BS_S >= PT_S)
                      && (bx_u + BS_U > pad_u)
                      && (bx_u < pad_u + PW_U);
        centre_left = (bx_u + HALF_B) < (pad_u + HALF_PW);

        // X axis: paddle picks a direction, a side wall then overrides it so
        // the ball is never steered back into the wall it just touched.
        ball_x_d = nx[9:0];
        dx_neg_d = dx_neg_q;
        if (paddle_hit)
            dx_neg_d = centre_left;
        if (nx <= 12'sd0) begin
            ball_x_d = '0;
            dx_neg_d = 1'b0;
        end else if (nx + BS_S >= HACT_S) begin
            ball_x_d = X_MAX;
            dx_neg_d = 1'b1;
        end

        // Y axis: ceiling and paddle are mutually exclusive (paddle needs
        // downward motion near the bottom).
        ball_y_d = ny[9:0];
        dy_neg_d = dy_neg_q;
        if (ny <= 12'sd0) begin
            ball_y_d = '0;
            dy_neg_d = 1'b0;
        end else if (paddle_hit) begin
            ball_y_d = PARK_Y;
            dy_neg_d = 1'b1;
        end

        run_miss = !paddle_hit && (ny >= VACT_S);

        // Parked position: centred on the paddle, clamped to the right edge.
        park_sum = pad_u + PARK_OFS;
        park_x   = (park_sum > {1'b0, X_MAX}) ? X_MAX : park_sum[9:0];
    end

    // ------------------------------------------------------------------
    // Pixel decode
    // ------------------------------------------------------------------
    logic pix_on;

    always_comb begin
        pix_on = ({1'b0, hor_count} >= bx_u)
              && ({1'b0, hor_count} <  bx_u + BS_U)
              && ({1'b0, ver_count} >= by_u)
              && ({1'b0, ver_count} <  by_u + BS_U)
              && (hor_count < 10'(H_ACTIVE))
              && (ver_count < 10'(V_ACTIVE))
              && ((state_q == ST_IDLE) || (state_q == ST_RUN));
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_25MH or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ball_x_q     <= RST_X;
            ball_y_q     <= PARK_Y;
            dx_neg_q     <= 1'b0;
            dy_neg_q     <= 1'b1;
            lives_q      <= 2'(LIVES);
            miss_cnt_q   <= '0;
            miss_pulse_q <= 1'b0;
            game_over_q  <= 1'b0;
            ball_rgb_q   <= COL_BG;
        end else begin
            miss_pulse_q <= 1'b0;
            ball_rgb_q   <= pix_on ? COL_BALL : COL_BG;

            if (tick) begin
                case (state_q)
                    ST_IDLE: begin
                        ball_x_q <= park_x;
                        ball_y_q <= PARK_Y;
                        if (launch) begin
                            state_q  <= ST_RUN;
                            dx_neg_q <= 1'b0;
                            dy_neg_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        ball_x_q <= ball_x_d;
                        ball_y_q <= ball_y_d;
                        dx_neg_q <= dx_neg_d;
                        dy_neg_q <= dy_neg_d;
                        if (run_miss) begin
                            miss_pulse_q <= 1'b1;
                            miss_cnt_q   <= '0;
                            if (lives_q > 2'd1) begin
                                lives_q <= lives_q - 2'd1;
                                state_q <= ST_MISS;
                            end else begin
                                lives_q     <= 2'd0;
                                state_q     <= ST_OVER;
                                game_over_q <= 1'b1;
                            end
                        end
                    end
                    ST_MISS: begin
                        // Park on the way out so the first frame back in
                        // IDLE already shows the ball on the paddle.
                        if (miss_cnt_q == MISS_LAST) begin
                            miss_cnt_q <= '0;
                            state_q    <= ST_IDLE;
                            ball_x_q   <= park_x;
                            ball_y_q   <= PARK_Y;
                        end else begin
                            miss_cnt_q <= miss_cnt_q + 1'b1;
                        end
                    end
                    default: ;  // ST_OVER: only reset leaves
                endcase
            end
        end
    end

    assign ball_rgb   = ball_rgb_q;
    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign lives      = lives_q;
    assign miss_pulse = miss_pulse_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: directed opening sequence from the test plan, then
// randomized scan positions, paddle positions and launch requests checked
// every cycle against a behavioural game model.
module tb_ball_engine;

    localparam int B  = 8;
    localparam int S  = 2;
    localparam int PW = 100;
    localparam int PT = 441;
    localparam int NL = 3;
    localparam int MF = 60;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_MISS = 2;
    localparam int M_OVER = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hor = 10'd100;
    logic [9:0] ver = 10'd100;
    logic [9:0] pad = 10'd270;
    logic       la  = 1'b0;
    logic [2:0] ball_rgb;
    logic [9:0] ball_x, ball_y;
    logic [1:0] lives;
    logic       miss_pulse, game_over;

    ball_engine dut (
        .CLK_25MH   (clk),
        .reset      (rst),
        .hor_count  (hor),
        .ver_count  (ver),
        .paddle_pos (pad),
        .launch     (la),
        .ball_rgb   (ball_rgb),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .lives      (lives),
        .miss_pulse (miss_pulse),
        .game_over  (game_over)
    );

    always #20 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int m_st, m_x, m_y, m_dx, m_dy, m_lives, m_cnt;
    int e_rgb, e_pulse;
    int n_miss = 0, n_hit = 0, n_over = 0;

    task automatic model_reset();
        m_st = M_IDLE; m_x = 316; m_y = PT - B; m_dx = S; m_dy = -S;
        m_lives = NL; m_cnt = 0; e_rgb = 0; e_pulse = 0;
    endtask

    task automatic park(input int p);
        m_x = (p + PW / 2 - B / 2 > 640 - B) ? 640 - B : p + PW / 2 - B / 2;
        m_y = PT - B;
    endtask

    function automatic bit pix(input int h, input int v);
        return (m_st == M_IDLE || m_st == M_RUN) && h >= m_x && h < m_x + B
            && v >= m_y && v < m_y + B && h < 640 && v < 480;
    endfunction

    task automatic model_tick(input int p, input bit l);
        int nx, ny, rx, ry, rdx, rdy;
        bit hit;
        case (m_st)
            M_IDLE: begin
                park(p);
                if (l) begin m_st = M_RUN; m_dx = S; m_dy = -S; end
            end
            M_RUN: begin
                nx = m_x + m_dx; ny = m_y + m_dy;
                hit = (m_dy > 0) && (m_y + B <= PT) && (ny + B >= PT)
                   && (m_x + B > p) && (m_x < p + PW);
                rx = nx; ry = ny; rdx = m_dx; rdy = m_dy;
                if (hit) begin
                    n_hit++;
                    ry = PT - B; rdy = -S;
                    rdx = (m_x + B / 2 < p + PW / 2) ? -S : S;
                end
                if (ny <= 0) begin ry = 0; rdy = S; end
                if (nx <= 0) begin rx = 0; rdx = S; end
                else if (nx + B >= 640) begin rx = 640 - B; rdx = -S; end
                m_x = rx; m_y = ry; m_dx = rdx; m_dy = rdy;
                if (!hit && ny >= 480) begin
                    n_miss++;
                    e_pulse = 1; m_cnt = 0;
                    if (m_lives > 1) begin m_lives--; m_st = M_MISS; end
                    else begin m_lives = 0; m_st = M_OVER; n_over++; end
                end
            end
            M_MISS: begin
                m_cnt++;
                if (m_cnt == MF) begin m_cnt = 0; m_st = M_IDLE; park(p); end
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        chk("ball_x", 32'(ball_x), 32'(m_x));
        chk("ball_y", 32'(ball_y), 32'(m_y));
        chk("lives", 32'(lives), 32'(m_lives));
        chk("game_over", 32'(game_over), 32'(m_st == M_OVER));
        chk("miss_pulse", 32'(miss_pulse), 32'(e_pulse));
        chk("ball_rgb", 32'(ball_rgb), 32'(e_rgb));
    endtask

    // Called at a falling edge: check, drive one cycle, advance the model.
    task automatic step(input int h, input int v, input int p, input bit l);
        check_outputs();
        hor = 10'(h); ver = 10'(v); pad = 10'(p); la = l;
        e_rgb   = pix(h, v) ? 7 : 0;
        e_pulse = 0;
        if (h == 0 && v == 480) model_tick(p, l);
        @(negedge clk);
    endtask

    // Assert reset between clock edges and check values before any edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_x", 32'(ball_x), 32'd316);
        chk("rst_y", 32'(ball_y), 32'd433);
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_rgb", 32'(ball_rgb), 32'd0);
        chk("rst_pulse", 32'(miss_pulse), 32'd0);
        chk("rst_over", 32'(game_over), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int clampi(input int a, input int lo, input int hi);
        return (a < lo) ? lo : (a > hi) ? hi : a;
    endfunction

    initial begin
        int over_ticks;
        model_reset();
        @(negedge clk);
        do_reset();

        // Opening sequence with paddle at 270
        step(0, 480, 270, 0);
        step(317, 434, 270, 0);
        chk("tp_rgb_on", 32'(ball_rgb), 32'd7);
        chk("tp_x", 32'(ball_x), 32'd316);
        chk("tp_y", 32'(ball_y), 32'd433);
        chk("tp_lives", 32'(lives), 32'd3);
        step(325, 434, 270, 0);
        chk("tp_rgb_off", 32'(ball_rgb), 32'd0);
        step(0, 480, 270, 1);
        for (int i = 0; i < 5; i++) step(0, 480, 270, 0);
        chk("tp_run_x", 32'(ball_x), 32'd326);
        chk("tp_run_y", 32'(ball_y), 32'd423);

        // Randomized play
        over_ticks = 0;
        for (int c = 0; c < 30000; c++) begin
            int r, h, v, p;
            bit l;
            if (m_st == M_OVER && over_ticks >= 4) begin
                check_outputs();
                hor = 10'($urandom_range(1, 639));
                ver = 10'($urandom_range(0, 479));
                do_reset();
                over_ticks = 0;
            end
            if ($urandom_range(0, 7) == 0) p = $urandom_range(0, 1023);
            else p = clampi(m_x + 4 - int'($urandom_range(0, 150)), 0, 1023);
            l = (m_st == M_OVER) ? 1'b1 : 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r < 3) begin
                h = 0; v = 480;
            end else if (r < 8) begin
                h = clampi(m_x - 2 + int'($urandom_range(0, 12)), 0, 799);
                v = clampi(m_y - 2 + int'($urandom_range(0, 12)), 0, 524);
            end else begin
                h = $urandom_range(0, 799);
                v = $urandom_range(0, 524);
            end
            if (h == 0 && v == 480 && m_st == M_OVER) over_ticks++;
            step(h, v, p, l);
        end
        check_outputs();

        $display("coverage: hits=%0d misses=%0d game_overs=%0d", n_hit, n_miss, n_over);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
